// File: rtl/adder_pkg.sv
// adder_pkg: shared state encoding and configuration helpers for chunked_adder.
package adder_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic bit cfg_ok(input int width, input int chunk);
        return chunk >= 1 && chunk <= width && width % chunk == 0;
    endfunction

    // A single-chunk build still needs a one-bit index register.
    function automatic int idx_width(input int nchunk);
        return nchunk > 1 ? $clog2(nchunk) : 1;
    endfunction
endpackage

// File: rtl/adder_chunk.sv
// adder_chunk: combinational CHUNK-bit ripple adder built from full-adder cells.
module adder_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb
);
    logic [CHUNK:0] c;
    assign c[0] = cin;
    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        logic x;
        assign x      = a[i] ^ b[i];
        assign s[i]   = x ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (x & c[i]);
    end
    assign cout  = c[CHUNK];
    assign c_msb = c[CHUNK-1];
endmodule

// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle add/subtract, CHUNK bits per clock, with
// valid/ready handshakes on operands and result.
module chunked_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW = idx_width(NCHUNK);

    if (!cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
        $error("chunked_adder: WIDTH must be a positive multiple of CHUNK");
    end

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic [IW-1:0]    idx_q;
    logic             carry_q, cout_q, ovf_q;
    logic [CHUNK-1:0] chunk_a, chunk_b, chunk_s;
    logic             chunk_c, chunk_cm, last;

    assign chunk_a = a_q[idx_q*CHUNK +: CHUNK];
    assign chunk_b = b_q[idx_q*CHUNK +: CHUNK];
    assign last    = idx_q == IW'(NCHUNK - 1);

    adder_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a     (chunk_a),
        .b     (chunk_b),
        .cin   (carry_q),
        .s     (chunk_s),
        .cout  (chunk_c),
        .c_msb (chunk_cm)
    );

    // b is stored already inverted for subtract, so the datapath only adds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    a_q     <= a;
                    b_q     <= b ^ {WIDTH{sub}};
                    carry_q <= cin;
                    idx_q   <= '0;
                    state_q <= RUN;
                end
                RUN: begin
                    sum_q[idx_q*CHUNK +: CHUNK] <= chunk_s;
                    carry_q <= chunk_c;
                    idx_q   <= last ? '0 : idx_q + IW'(1);
                    if (last) begin
                        cout_q  <= chunk_c;
                        ovf_q   <= chunk_c ^ chunk_cm;
                        state_q <= DONE;
                    end
                end
                DONE: if (out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_chunked_adder.sv
// tb_chunked_adder: directed and random checks of three chunked_adder builds
// (CHUNK=4, 16, 1) against an arithmetic reference model.
module tb_chunked_adder;
    localparam int LAT[3] = '{4, 1, 16};

    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready, cin, sub;
    logic [15:0] a, b;
    logic [15:0] sum_w[3];
    logic        ir[3], ov[3], cout_w[3], ovf_w[3];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    chunked_adder #(.WIDTH(16), .CHUNK(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(ov[0]), .out_ready(out_ready),
        .sum(sum_w[0]), .cout(cout_w[0]), .ovf(ovf_w[0])
    );
    chunked_adder #(.WIDTH(16), .CHUNK(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(ov[1]), .out_ready(out_ready),
        .sum(sum_w[1]), .cout(cout_w[1]), .ovf(ovf_w[1])
    );
    chunked_adder #(.WIDTH(16), .CHUNK(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(ov[2]), .out_ready(out_ready),
        .sum(sum_w[2]), .cout(cout_w[2]), .ovf(ovf_w[2])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [15:0] ta, tb, input logic tc, ts,
                         output logic [15:0] es, output logic ec, eo);
        logic [15:0] be;
        logic [16:0] full;
        be   = tb ^ {16{ts}};
        full = {1'b0, ta} + {1'b0, be} + 17'(tc);
        es   = full[15:0];
        ec   = full[16];
        eo   = (ta[15] == be[15]) && (full[15] != ta[15]);
    endtask

    // One operation on all builds with out_ready held high; each build is checked
    // when its out_valid first rises, including the cycle count from acceptance.
    task automatic do_op(input logic [15:0] ta, tb, input logic tc, ts);
        logic [15:0] es;
        logic        ec, eo;
        bit          seen[3];
        model(ta, tb, tc, ts, es, ec, eo);
        seen = '{0, 0, 0};
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk($sformatf("in_ready_pre[%0d]", i), 32'(ir[i]), 1);
        a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) if (ov[i] && !seen[i]) begin
                seen[i] = 1'b1;
                chk($sformatf("latency[%0d]", i), 32'(k), 32'(LAT[i]));
                chk($sformatf("sum[%0d]", i), 32'(sum_w[i]), 32'(es));
                chk($sformatf("cout[%0d]", i), 32'(cout_w[i]), 32'(ec));
                chk($sformatf("ovf[%0d]", i), 32'(ovf_w[i]), 32'(eo));
            end
        end
        for (int i = 0; i < 3; i++) chk($sformatf("result_seen[%0d]", i), 32'(seen[i]), 1);
        chk("sum_hold", 32'(sum_w[0]), 32'(es));
        chk("out_valid_after", 32'(ov[0]), 0);
    endtask

    initial begin
        logic [15:0] es;
        logic        ec, eo;
        bit          pulse;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(ir[0]), 1);
        chk("rst_out_valid", 32'(ov[0]), 0);
        chk("rst_sum", 32'(sum_w[0]), 0);
        chk("rst_cout", 32'(cout_w[0]), 0);
        chk("rst_ovf", 32'(ovf_w[0]), 0);
        rst = 1'b0;

        do_op(16'h1234, 16'h0FCD, 1'b0, 1'b0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        do_op(16'h0005, 16'h0007, 1'b1, 1'b1);
        do_op(16'h8000, 16'h0001, 1'b1, 1'b1);

        // Backpressure: result must hold and new operands be ignored.
        @(negedge clk);
        a = 16'h00FF; b = 16'h0F01; cin = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("bp_not_early", 32'(ov[0]), 0);
        @(negedge clk);
        chk("bp_valid", 32'(ov[0]), 1);
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_valid_hold", 32'(ov[0]), 1);
            chk("bp_sum_hold", 32'(sum_w[0]), 32'h1000);
            chk("bp_cout_hold", 32'(cout_w[0]), 0);
            chk("bp_ovf_hold", 32'(ovf_w[0]), 0);
            chk("bp_in_ready", 32'(ir[0]), 0);
        end
        repeat (4) @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk($sformatf("bp_release[%0d]", i), 32'(ir[i]), 1);
        chk("bp_valid_drop", 32'(ov[0]), 0);
        chk("bp_sum_after", 32'(sum_w[0]), 32'h1000);

        // Reset during the second RUN cycle of the CHUNK=4 build.
        a = 16'h1111; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_sum", 32'(sum_w[0]), 0);
        chk("mid_rst_out_valid", 32'(ov[0]), 0);
        chk("mid_rst_in_ready", 32'(ir[0]), 1);
        chk("mid_rst_dut1_valid", 32'(ov[2]), 0);
        chk("mid_rst_dut1_sum", 32'(sum_w[2]), 0);
        @(negedge clk);
        rst = 1'b0;
        pulse = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) pulse |= ov[i];
        end
        chk("mid_rst_no_pulse", 32'(pulse), 0);
        do_op(16'h0001, 16'h0001, 1'b0, 1'b0);

        for (int n = 0; n < 1000; n++)
            do_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));

        model(16'h1234, 16'h0FCD, 1'b0, 1'b0, es, ec, eo);
        chk("model_sanity", 32'({ec, eo, es}), 32'h2201);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/chunked_adder.md
# chunked_adder

Multi-cycle, parametrised binary adder/subtractor that adds two WIDTH-bit operands CHUNK bits per clock, carrying between chunks in a register. It extends our single-bit full-adder cell into a word-level arithmetic unit with registered results, a subtract mode, a signed-overflow flag and valid/ready handshakes on both sides. It sits between an operand producer and a result consumer where area matters more than single-cycle throughput.

## Interface
- WIDTH, 16, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits processed per cycle; 1 ≤ CHUNK ≤ WIDTH.
- Derived: NCHUNK = WIDTH/CHUNK.

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in to bit 0
- sub  in  1  1: B is bitwise inverted before addition
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- cout  out  1  carry out of bit WIDTH-1
- ovf  out  1  two's-complement overflow

## Operation
- Result = a + (b ^ {WIDTH{sub}}) + cin, modulo 2^WIDTH; cout = bit WIDTH of the full sum. Plain subtraction a−b: sub=1, cin=1.
- ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]), b_eff = b ^ {WIDTH{sub}}.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On in_valid: latch a, b_eff, cin; chunk index ← 0; carry register ← cin; → RUN.
  - RUN: each cycle add chunk [idx*CHUNK +: CHUNK] of A and B_eff with carry register; write partial sum into sum register; update carry; idx++. After chunk NCHUNK−1: capture cout, ovf; → DONE.
  - DONE: out_valid=1; sum/cout/ovf stable. On out_ready: → IDLE.
- in_ready=0 in RUN and DONE; input changes during RUN/DONE ignored.
- sum, cout, ovf hold last result after handshake until the next result overwrites them; partial sum bits may change during RUN, only valid when out_valid=1.
- Reset (any time, incl. mid-RUN or DONE): state → IDLE; sum, cout, ovf, carry, idx ← 0; out_valid=0; in_ready=1 once rst deasserts. In-flight operation is discarded, no result emitted.

## Timing
- Acceptance at edge T (in_valid && in_ready). RUN occupies edges T+1 … T+NCHUNK; out_valid high from edge T+NCHUNK.
- Latency: NCHUNK cycles accept-to-out_valid.
- Output handshake at edge U (out_valid && out_ready); in_ready high from edge U; next accept earliest at U+1.
- Max throughput: one operation per NCHUNK+2 cycles with out_ready held high.
- NCHUNK=1 (CHUNK=WIDTH): RUN lasts one cycle, latency 1.
- out_valid, in_ready decoded from registered state only; no combinational path from in_valid/out_ready to any output.
- Reset values: in_ready=1, out_valid=0, sum=0, cout=0, ovf=0.

## Structure
- Shared package adder_pkg: state enum typedef (IDLE, RUN, DONE); elaboration check function/localparam asserting WIDTH % CHUNK == 0.
- Sub-module adder_chunk: combinational CHUNK-bit ripple adder built from full-adder cells (sum = x^cin, carry = a&b | x&cin per bit); ports a, b, cin, s, cout, plus carry into its MSB for overflow. Top level holds FSM, operand/sum registers, carry register, chunk index (width clog2(NCHUNK), min 1).

## Test plan
All with WIDTH=16, CHUNK=4 unless noted.
- a=0x1234, b=0x0FCD, cin=0, sub=0 -> sum=0x2201, cout=0, ovf=0; out_valid exactly 4 cycles after acceptance edge.
- a=0x7FFF, b=0x0001, cin=0, sub=0 -> sum=0x8000, cout=0, ovf=1; a=0xFFFF, b=0x0001 -> sum=0x0000, cout=1, ovf=0.
- a=0x0005, b=0x0007, sub=1, cin=1 -> sum=0xFFFE, cout=0, ovf=0; a=0x8000, b=0x0001, sub=1, cin=1 -> sum=0x7FFF, cout=1, ovf=1.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> sum/cout/ovf/out_valid stable, in_ready=0; new in_valid ignored until handshake, in_ready=1 the cycle after.
- Reset asserted during 2nd RUN cycle -> outputs immediately 0, in_ready=1 after deassert, no out_valid pulse; next operation 0x0001+0x0001 -> 0x0002.
- CHUNK=16 and CHUNK=1 builds: random 1000 operations vs. reference model, latency 1 and 16 respectively.
